// File: rtl/vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// vga_timing_ctrl
//
// Purpose:
//   Scan sequencer for the VGA datapath. Divides the system clock into a
//   pixel-rate tick, runs the horizontal/vertical scan counters, decodes the
//   sync pulses and visible window, and arbitrates the display-update port so
//   that game logic only touches frame state during vertical blanking.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   pix_tick     out  one-clk pulse every CLK_DIV clks
//   h_count      out  horizontal position 0..H_TOTAL-1
//   v_count      out  vertical line 0..V_TOTAL-1
//   hsync        out  active-low horizontal sync
//   vsync        out  active-low vertical sync
//   video_on     out  high inside the visible area
//   frame_start  out  one-clk pulse when the counters wrap to (0,0)
//   upd_req      in   update-port request (level)
//   upd_done     in   one-clk pulse, requester finished
//   upd_gnt      out  update-port grant
//   upd_abort    out  one-clk pulse, grant revoked at frame end
// ---------------------------------------------------------------------------
module vga_timing_ctrl #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_tick,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start,
    input  logic       upd_req,
    input  logic       upd_done,
    output logic       upd_gnt,
    output logic       upd_abort
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST       = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GRANT
    } arbState_e;

    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic [9:0]       hCount_q, hCount_d;
    logic [9:0]       vCount_q, vCount_d;
    logic             pixTick_q;
    logic             hsync_q, vsync_q, videoOn_q;
    logic             frameStart_q;
    logic             updAbort_q, updAbort_d;
    arbState_e        state_q, state_d;

    logic advance;
    logic hWrap;
    logic vWrap;
    logic frameWrap;
    logic inVblank;

    // Divider and scan-counter next state. Counters step in the same edge
    // that raises pix_tick, so the tick and the new position appear together.
    always_comb begin
        advance   = (divCnt_q == DIV_LAST);
        hWrap     = (hCount_q == H_LAST);
        vWrap     = (vCount_q == V_LAST);
        frameWrap = advance && hWrap && vWrap;
        divCnt_d  = advance ? '0 : divCnt_q + 1'b1;
        hCount_d  = hCount_q;
        vCount_d  = vCount_q;
        if (advance) begin
            if (hWrap) begin
                hCount_d = '0;
                vCount_d = vWrap ? '0 : vCount_q + 10'd1;
            end else begin
                hCount_d = hCount_q + 10'd1;
            end
        end
    end

    // Datapath registers. Decode is computed from the next counter values so
    // the registered sync/window flags always match the registered counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt_q     <= '0;
            hCount_q     <= '0;
            vCount_q     <= '0;
            pixTick_q    <= 1'b0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            videoOn_q    <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            divCnt_q     <= divCnt_d;
            hCount_q     <= hCount_d;
            vCount_q     <= vCount_d;
            pixTick_q    <= advance;
            frameStart_q <= frameWrap;
            if (advance) begin
                hsync_q   <= !((hCount_d >= H_SYNC_START) && (hCount_d < H_SYNC_END));
                vsync_q   <= !((vCount_d >= V_SYNC_START) && (vCount_d < V_SYNC_END));
                videoOn_q <= (hCount_d < H_VIS) && (vCount_d < V_VIS);
            end
        end
    end

    // The last line is excluded so a new grant always has at least one full
    // blanking line before the frame wraps.
    assign inVblank = (vCount_q >= V_VIS) && (vCount_q != V_LAST);

    // Arbiter state register; abort pulse registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            updAbort_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            updAbort_q <= updAbort_d;
        end
    end

    // Arbiter next state. Only upd_done or the frame wrap end a grant; a
    // done arriving together with the wrap counts as normal completion.
    always_comb begin
        state_d    = state_q;
        updAbort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (upd_req) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!upd_req)     state_d = ST_IDLE;
                else if (inVblank) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (upd_done) begin
                    state_d = ST_IDLE;
                end else if (frameWrap) begin
                    state_d    = ST_IDLE;
                    updAbort_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pix_tick    = pixTick_q;
    assign h_count     = hCount_q;
    assign v_count     = vCount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = videoOn_q;
    assign frame_start = frameStart_q;
    assign upd_gnt     = (state_q == ST_GRANT);
    assign upd_abort   = updAbort_q;

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Sequencer for the VGA scan datapath. It divides the system clock into a pixel-rate enable and drives the horizontal and vertical scan counters. From those counters it decodes hsync, vsync and the visible-area window. It also arbitrates one shared resource, the display-update port used by game logic: access is granted only inside vertical blanking, so frame-buffer/pattern state never changes mid-scan.

## Interface
Parameters:
- CLK_DIV, 4: system clocks per pixel (100 MHz → 25 MHz); must be ≥2
- H_VISIBLE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal segments in pixels; H_TOTAL = sum = 800
- V_VISIBLE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical segments in lines; V_TOTAL = sum = 525

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pix_tick  out  1  one-clk pulse, once per CLK_DIV clks
- h_count  out  10  horizontal position, 0..H_TOTAL-1
- v_count  out  10  vertical line, 0..V_TOTAL-1
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- video_on  out  1  high while (h_count, v_count) is in the visible area
- frame_start  out  1  one-clk pulse when counters wrap to (0,0)
- upd_req  in  1  update-port request, level, held until granted or withdrawn
- upd_done  in  1  one-clk pulse: requester is finished
- upd_gnt  out  1  update-port grant
- upd_abort  out  1  one-clk pulse: grant revoked at frame end

## Operation
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_tick is registered, high in the clk following div_cnt==CLK_DIV-1.
- Counters: advance only on pix_tick.
  - h_count: H_TOTAL-1 → 0; on that wrap v_count increments.
  - v_count: V_TOTAL-1 → 0 when h_count also wraps.
  - No other increment path; values ≥ TOTAL are unreachable.
- Decode: hsync, vsync and video_on are registered, updated in the same edge as the counters, so they always describe the current counter values.
  - hsync = 0 iff H_VISIBLE+H_FP ≤ h_count < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vsync = 0 iff V_VISIBLE+V_FP ≤ v_count < V_VISIBLE+V_FP+V_SYNC (490..491).
  - video_on = 1 iff h_count < H_VISIBLE and v_count < V_VISIBLE.
- frame_start: high in the same clk the counters become (0,0) through a wrap. Not asserted at reset.
- in_vblank = (v_count ≥ V_VISIBLE) and (v_count ≠ V_TOTAL-1). Grants are never started on the last line.
- Arbiter FSM (Moore), states IDLE, WAIT, GRANT; upd_gnt = (state==GRANT):
  - IDLE: upd_req → WAIT.
  - WAIT: !upd_req → IDLE. Otherwise in_vblank → GRANT.
  - GRANT: upd_done → IDLE. Else frame_start → IDLE with upd_abort pulsed in the same edge.
  - Simultaneous upd_done and frame_start: normal completion, no abort.
  - upd_done outside GRANT is ignored.
  - upd_req dropping in GRANT does not release; only upd_done or abort release.

## Timing
- Reset (async assert, sync release):
  - div_cnt=0, h_count=0, v_count=0, state=IDLE.
  - pix_tick=0, hsync=1, vsync=1, video_on=0, frame_start=0, upd_gnt=0, upd_abort=0.
- First pix_tick: the CLK_DIV-th clk after release.
- Pixel (0,0) of the first frame after reset is blanked (video_on=0); every later frame shows video_on=1 at (0,0).
- Counter wrap period:
  - Line: H_TOTAL·CLK_DIV clks = 3200.
  - Frame: 1,680,000 clks with defaults.
- Grant latency: upd_req sampled high at edge k during vblank → upd_gnt high after edge k+1.
  - If upd_req rises during the visible area, the grant follows at the first edge where in_vblank is true.
- Release: upd_gnt falls one edge after upd_done is sampled.
- Forced release: at frame_start, the edge where v_count becomes 0.
- Reset mid-grant: upd_gnt drops asynchronously; no upd_abort pulse.

## Test plan
- Reset then run 20 clks (CLK_DIV=4) → pix_tick at clks 4, 8, 12…; h_count 0→1→2; outputs match reset values before the first tick.
- Run one line → hsync low exactly for h_count 656..751 (96 ticks = 384 clks); h_count wraps 799→0 with v_count 0→1; video_on low from h=640.
- Run one frame → vsync low for v_count 490..491; frame_start exactly once, at 1,680,000 clks; v_count 524→0.
- Raise upd_req at v_count=100 → upd_gnt stays 0 until v_count becomes 480, then asserts within 2 clks; pulse upd_done → upd_gnt 0 next edge, no upd_abort.
- Grant at v_count=523, never send upd_done → upd_gnt drops and upd_abort pulses in the frame_start clk; upd_req at v_count=524 alone → no grant until v_count=480 of the next frame.
- Assert rst_n=0 mid-grant at h_count=300 → all outputs return to reset values immediately; counters restart from (0,0).
